mdu_iter: RTL and testbench

//  Parametrised HI/LO multiply-divide unit for the E stage of the pipelined MIPS core.

---
 rtl/mdu_iter_pkg.sv | 39 +++
 rtl/mdu_iter_div_core.sv | 74 +++++++
 rtl/mdu_iter.sv | 163 ++++++++++++++++
 tb/tb_mdu_iter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_iter_pkg : op codes, controller states and op-class helpers for MDU    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package mdu_iter_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_MULT  = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_DIV   = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {MDU_MULTU, MDU_MULT, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {MDU_DIVU, MDU_DIV};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_core : iterative restoring divider, one quotient bit per cycle         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module div_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_kill,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r,
    output logic             o_valid
);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_qneg;
    logic             r_rneg;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_sub;
    logic             w_fits;

    assign w_a_mag  = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag  = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Remainder can transiently need one extra bit after the shift.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_sub    = w_rem_sh - {1'b0, r_div};
    assign w_fits   = (w_rem_sh >= {1'b0, r_div});

    always_ff @(posedge clk) begin
        if (reset || i_kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(WIDTH);
            r_rem  <= '0;
            r_quo  <= w_a_mag;
            r_div  <= w_b_mag;
            r_qneg <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_rneg <= i_signed & i_a[WIDTH-1];
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
                r_rem <= w_fits ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_busy && (r_cnt == '0);
    assign o_q     = r_qneg ? -r_quo : r_quo;
    assign o_r     = r_rneg ? -r_rem : r_rem;

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_iter : HI/LO multiply/divide unit with accumulate modes and flush      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [3:0]       mult_div_op,
    input  logic             start,
    output logic             Busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [WIDTH-1:0] c_WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t         r_state;
    logic [3:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_dz_hi;
    logic               r_dz;
    logic               r_ovf;
    logic               r_done;

    logic               w_idle;
    logic               w_accept_mul;
    logic               w_accept_div;
    logic               w_sgn;
    logic [2*WIDTH-1:0] w_opa;
    logic [2*WIDTH-1:0] w_opb;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [2*WIDTH-1:0] w_div_res;
    logic               w_div_busy;
    logic               w_div_valid;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept_mul = w_idle && start && is_mul_op(mult_div_op);
    assign w_accept_div = w_idle && start && is_div_op(mult_div_op);

    // Low 2*WIDTH bits of an extended product equal the signed/unsigned product.
    assign w_sgn  = is_signed_op(mult_div_op);
    assign w_opa  = {{WIDTH{w_sgn & D1[WIDTH-1]}}, D1};
    assign w_opb  = {{WIDTH{w_sgn & D2[WIDTH-1]}}, D2};
    assign w_prod = w_opa * w_opb;

    always_comb begin
        w_mul_res = r_prod;
        case (r_op)
            MDU_MADD, MDU_MADDU: w_mul_res = {r_hi, r_lo} + r_prod;
            MDU_MSUB, MDU_MSUBU: w_mul_res = {r_hi, r_lo} - r_prod;
            default:             w_mul_res = r_prod;
        endcase
    end

    div_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk      (clk),
        .reset    (reset),
        .i_kill   (flush),
        .i_start  (w_accept_div && !flush),
        .i_signed (mult_div_op == MDU_DIV),
        .i_a      (D1),
        .i_b      (D2),
        .o_busy   (w_div_busy),
        .o_q      (w_div_q),
        .o_r      (w_div_r),
        .o_valid  (w_div_valid)
    );

    always_comb begin
        w_div_res = {w_div_r, w_div_q};
        if (r_dz) begin
            w_div_res = {r_dz_hi, {WIDTH{1'b1}}};
        end else if (r_ovf) begin
            w_div_res = {{WIDTH{1'b0}}, c_WORD_MIN};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= MDU_NONE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz_hi <= '0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept_mul) begin
                            r_state <= ST_MUL;
                            r_op    <= mult_div_op;
                            r_prod  <= w_prod;
                            r_cnt   <= CNT_W'(MULT_LAT - 1);
                        end else if (w_accept_div) begin
                            r_state <= ST_DIV;
                            r_op    <= mult_div_op;
                            r_dz_hi <= D1;
                            r_dz    <= (D2 == '0);
                            r_ovf   <= (mult_div_op == MDU_DIV) && (D1 == c_WORD_MIN) && (D2 == '1);
                        end else if (mult_div_op == MDU_MTHI) begin
                            r_hi <= D1;
                        end else if (mult_div_op == MDU_MTLO) begin
                            r_lo <= D1;
                        end
                    end
                    ST_MUL: begin
                        if (r_cnt == '0) begin
                            {r_hi, r_lo} <= w_mul_res;
                            r_done       <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_DIV: begin
                        if (w_div_busy && w_div_valid) begin
                            {r_hi, r_lo} <= w_div_res;
                            r_done       <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign Busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdu_iter : directed vectors plus cycle-level reference model for MDU    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_mdu_iter;

    localparam int W   = 32;
    localparam int LAT = 5;
    localparam int CW  = 6;

    localparam logic [3:0] OP_NONE = 0, OP_MULTU = 1, OP_MULT = 2, OP_DIVU = 3, OP_DIV = 4,
                           OP_MTHI = 5, OP_MTLO = 6, OP_MADD = 7, OP_MADDU = 8,
                           OP_MSUB = 9, OP_MSUBU = 10;

    logic         clk = 1'b0;
    logic         reset, flush, start;
    logic [W-1:0] D1, D2;
    logic [3:0]   op;
    logic         Busy, done;
    logic [W-1:0] HI, LO;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .MULT_LAT(LAT), .CNT_W(CW)) dut (
        .clk (clk), .reset (reset), .flush (flush), .D1 (D1), .D2 (D2),
        .mult_div_op (op), .start (start), .Busy (Busy), .done (done), .HI (HI), .LO (LO)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edge-count view of the unit, result computed with plain arithmetic.
    logic [W-1:0]   m_hi, m_lo, m_rhi, m_rlo;
    logic [2*W-1:0] m_prod, m_acc;
    logic [3:0]     m_op;
    bit             m_busy, m_done, m_live = 1'b0;
    int             m_left;
    longint         sa, sb;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_live = 1;
        end else if (m_live) begin
            m_done = 0;
            if (flush) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_acc = {m_hi, m_lo};
                    case (m_op)
                        OP_MADD, OP_MADDU: {m_hi, m_lo} = m_acc + m_prod;
                        OP_MSUB, OP_MSUBU: {m_hi, m_lo} = m_acc - m_prod;
                        OP_DIV, OP_DIVU:   {m_hi, m_lo} = {m_rhi, m_rlo};
                        default:           {m_hi, m_lo} = m_prod;
                    endcase
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (start && op inside {OP_MULTU, OP_MULT, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU}) begin
                m_busy = 1; m_op = op; m_left = LAT;
                if (op inside {OP_MULT, OP_MADD, OP_MSUB}) begin
                    sa = longint'($signed(D1)); sb = longint'($signed(D2));
                    m_prod = sa * sb;
                end else begin
                    m_prod = {32'b0, D1} * {32'b0, D2};
                end
            end else if (start && op inside {OP_DIVU, OP_DIV}) begin
                m_busy = 1; m_op = op; m_left = W + 1;
                if (D2 == 0) begin
                    m_rhi = D1; m_rlo = '1;
                end else if (op == OP_DIV) begin
                    sa = longint'($signed(D1)); sb = longint'($signed(D2));
                    m_rlo = 32'(sa / sb); m_rhi = 32'(sa % sb);
                end else begin
                    m_rlo = D1 / D2; m_rhi = D1 % D2;
                end
            end else if (op == OP_MTHI) begin
                m_hi = D1;
            end else if (op == OP_MTLO) begin
                m_lo = D1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model.Busy", {31'b0, Busy}, {31'b0, m_busy});
            chk("model.done", {31'b0, done}, {31'b0, m_done});
            chk("model.HI", HI, m_hi);
            chk("model.LO", LO, m_lo);
        end
    end

    // All tasks start and end on a negedge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; D1 = a; D2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
    endtask

    task automatic mt(input logic [3:0] o, input logic [W-1:0] a);
        op = o; D1 = a;
        @(negedge clk);
        op = OP_NONE;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 100) chk("timeout", 32'(cyc), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int ebusy);
        int cyc;
        issue(o, a, b);
        wait_idle(cyc);
        chk({name, ".busy_cycles"}, 32'(cyc), 32'(ebusy));
        chk({name, ".done"}, {31'b0, done}, 32'd1);
        chk({name, ".HI"}, HI, ehi);
        chk({name, ".LO"}, LO, elo);
        @(negedge clk);
        chk({name, ".done_once"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int cyc, ndone;
        reset = 1'b1; flush = 1'b0; start = 1'b0; op = OP_NONE; D1 = '0; D2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset.HI", HI, 32'h0);
        chk("reset.LO", LO, 32'h0);
        chk("reset.Busy", {31'b0, Busy}, 32'd0);
        chk("reset.done", {31'b0, done}, 32'd0);

        run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, LAT);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, W + 1);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, W + 1);
        run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, W + 1);
        run_op("divu_big", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, W + 1);
        run_op("div_zero", OP_DIV, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, W + 1);
        run_op("divu_zero", OP_DIVU, 32'h87654321, 32'd0, 32'h87654321, 32'hFFFFFFFF, W + 1);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, W + 1);

        mt(OP_MTHI, 32'd1);
        mt(OP_MTLO, 32'hFFFFFFFF);
        chk("mthi", HI, 32'd1);
        chk("mtlo", LO, 32'hFFFFFFFF);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'd2, 32'd0, LAT);
        run_op("msub", OP_MSUB, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, LAT);
        mt(OP_MTHI, 32'd0);
        mt(OP_MTLO, 32'd0);
        run_op("madd", OP_MADD, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, LAT);
        run_op("msubu", OP_MSUBU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFD, LAT);

        // Flush part way through a divide: nothing commits, no done.
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd16);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.Busy", {31'b0, Busy}, 32'd0);
        chk("flush.HI", HI, 32'hFFFFFFFD);
        chk("flush.LO", LO, 32'hFFFFFFFD);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("flush.no_done", 32'(ndone), 32'd0);
        run_op("after_flush", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, LAT);

        // Back-to-back: next start issued on the cycle Busy first reads 0.
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_idle(cyc);
        issue(OP_MULTU, 32'h10000, 32'h10000);
        chk("b2b.Busy", {31'b0, Busy}, 32'd1);
        wait_idle(cyc);
        chk("b2b.HI", HI, 32'd1);
        chk("b2b.LO", LO, 32'd0);
        @(negedge clk);

        // Reset in the middle of a divide.
        issue(OP_DIV, 32'd100, 32'd3);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset.HI", HI, 32'd0);
        chk("midreset.LO", LO, 32'd0);
        chk("midreset.Busy", {31'b0, Busy}, 32'd0);

        // Start and mtlo suppressed by flush in the same cycle.
        mt(OP_MTHI, 32'hAAAA);
        flush = 1'b1;
        issue(OP_MULT, 32'd9, 32'd9);
        chk("flushstart.Busy", {31'b0, Busy}, 32'd0);
        mt(OP_MTLO, 32'd5);
        flush = 1'b0;
        chk("flushstart.HI", HI, 32'hAAAA);
        chk("flushmt.LO", LO, 32'd0);

        // mthi while busy is ignored; accumulate sees the old HI.
        issue(OP_MADDU, 32'd2, 32'd3);
        mt(OP_MTHI, 32'h5555);
        wait_idle(cyc);
        chk("busy_mthi.HI", HI, 32'hAAAA);
        chk("busy_mthi.LO", LO, 32'd6);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
